jtframe_ddr_arb2: RTL and testbench
===================================

JTFRAME_DDR_ARB2 -- requirements
Module: jtframe_ddr_arb2

Interface
REQ-001 Parameter AW, default 29: DDR word address width.
REQ-002 Parameter BW, default 8: burst count width.
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 mN_rd  in  1  read request from master N (N=0 frame buffer, N=1 secondary); held until accepted.
REQ-006 mN_we  in  1  write beat valid from master N.
REQ-007 mN_addr  in  AW  burst start address, sampled with the first beat or read command.
REQ-008 mN_burstcnt  in  BW  burst length in 64-bit beats.
REQ-009 mN_din / mN_be  in  64 / 8  write data / byte enables.
REQ-010 mN_busy  out  1  wait request to master N.
REQ-011 mN_dout / mN_dout_ready  out  64 / 1  read data (broadcast) / read beat strobe (granted reader only).
REQ-012 ddram_clk  out  1  equals clk.
REQ-013 ddram_rd, ddram_we, ddram_addr, ddram_burstcnt, ddram_din, ddram_be  out  widths as mN_*  forwarded command of the granted master.
REQ-014 ddram_busy, ddram_dout, ddram_dout_ready  in  1/64/1  DDR wait request, read data, read beat strobe.
REQ-015 st_addr  in  8  status select; st_dout  out  8  status byte.

Function
REQ-016 FSM states: IDLE, CMD, RDATA, WDATA; grant register gnt (0/1) and last-served register lst.
REQ-017 IDLE: a master requests when rd|we is high; if only one requests, it is granted; if both, the master != lst is granted; the next cycle is CMD.
REQ-018 IDLE: all ddram_rd/ddram_we low, both mN_busy high, both mN_dout_ready low.
REQ-019 CMD/WDATA: ddram_* command outputs combinationally equal the granted master's signals; granted mN_busy = ddram_busy; other master's busy = 1.
REQ-020 CMD, granted rd & !we & !ddram_busy: latch burstcnt into beat counter, go to RDATA.
REQ-021 CMD, granted we & !ddram_busy: first beat accepted; if burstcnt<=1 go to IDLE, else latch burstcnt-1 remaining and go to WDATA.
REQ-022 rd and we both high from one master: treated as write.
REQ-023 CMD with granted rd and we both low: abort, return to IDLE with no DDR access, lst unchanged.
REQ-024 RDATA: ddram_rd low; each ddram_dout_ready decrements counter and pulses granted mN_dout_ready in the same cycle; after last beat, IDLE next cycle.
REQ-025 WDATA: each cycle with granted we & !ddram_busy decrements remaining; reaching 0 -> IDLE; we low inserts wait cycles, never aborts.
REQ-026 burstcnt of 0 is treated as 1.
REQ-027 lst <= gnt on every return to IDLE from RDATA or WDATA.
REQ-028 ddram_dout_ready outside RDATA is ignored and not forwarded.
REQ-029 mN_dout = ddram_dout for both masters at all times.
REQ-030 Status: st_addr[1:0]=0 -> {4'd0, lst, gnt, state[1:0]}; 1 -> completed-burst count of master 0, 8-bit wrapping; 2 -> same for master 1; 3 -> 8'h00; st_addr[7:2] ignored.
REQ-031 Counters increment once per completed burst (RDATA/WDATA exit), not on aborts.

Reset
REQ-032 rst high forces IDLE, gnt=0, lst=1, beat counters and status counters 0, ddram_rd/we low, mN_busy high, mN_dout_ready low, immediately and independent of clk.
REQ-033 Reset mid-burst abandons the burst; in-flight read beats arriving after reset are dropped per REQ-028.

Verification
REQ-034 After reset, m0 read burstcnt=4 addr=0x100, ddram_busy low -> ddram_rd high one cycle at addr 0x100, 4 beats forwarded to m0 only, st_dout(addr 1)=1.
REQ-035 m0 and m1 both request reads in IDLE after reset (lst=1) -> m0 served first, then m1; repeat -> alternates m0,m1.
REQ-036 m1 write burstcnt=3, ddram_busy high 2 cycles on beat 2 -> exactly 3 accepted beats, m0_busy high throughout, IDLE after beat 3.
REQ-037 m0 drops rd in CMD while ddram_busy high -> IDLE, no counter change, lst unchanged.
REQ-038 Assert rst during RDATA after 2 of 8 beats, release, issue m1 read burstcnt=2 while 6 stale beats arrive in IDLE/CMD -> stale beats dropped; m1 receives only its 2 beats.
REQ-039 burstcnt=0 write from m0 -> single beat accepted, state returns to IDLE.

Source files
------------

// File: rtl/jtframe_ddr_arb2.sv
// Two-master DDR burst arbiter: grants one master at a time (alternating on
// contention), forwards its read or write burst and keeps status counters.
module jtframe_ddr_arb2 #(
    parameter int unsigned AW = 29,
    parameter int unsigned BW = 8
) (
    input  logic          clk,
    input  logic          rst,
    // master 0 (frame buffer)
    input  logic          m0_rd,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [BW-1:0] m0_burstcnt,
    input  logic [63:0]   m0_din,
    input  logic [7:0]    m0_be,
    output logic          m0_busy,
    output logic [63:0]   m0_dout,
    output logic          m0_dout_ready,
    // master 1 (secondary)
    input  logic          m1_rd,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [BW-1:0] m1_burstcnt,
    input  logic [63:0]   m1_din,
    input  logic [7:0]    m1_be,
    output logic          m1_busy,
    output logic [63:0]   m1_dout,
    output logic          m1_dout_ready,
    // DDR side
    output logic          ddram_clk,
    output logic          ddram_rd,
    output logic          ddram_we,
    output logic [AW-1:0] ddram_addr,
    output logic [BW-1:0] ddram_burstcnt,
    output logic [63:0]   ddram_din,
    output logic [7:0]    ddram_be,
    input  logic          ddram_busy,
    input  logic [63:0]   ddram_dout,
    input  logic          ddram_dout_ready,
    // status
    input  logic [7:0]    st_addr,
    output logic [7:0]    st_dout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_RDATA = 2'd2,
        ST_WDATA = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          gnt_q, gnt_d;
    logic          lst_q, lst_d;
    logic [BW-1:0] beats_q, beats_d;
    logic [7:0]    done0_q, done0_d;
    logic [7:0]    done1_q, done1_d;
    logic          burst_done;

    logic          g_rd, g_we;
    logic [AW-1:0] g_addr;
    logic [BW-1:0] g_burst;
    logic [63:0]   g_din;
    logic [7:0]    g_be;
    logic          req0, req1;
    logic          unused_st;

    assign req0    = m0_rd | m0_we;
    assign req1    = m1_rd | m1_we;
    assign g_rd    = gnt_q ? m1_rd       : m0_rd;
    assign g_we    = gnt_q ? m1_we       : m0_we;
    assign g_addr  = gnt_q ? m1_addr     : m0_addr;
    assign g_burst = gnt_q ? m1_burstcnt : m0_burstcnt;
    assign g_din   = gnt_q ? m1_din      : m0_din;
    assign g_be    = gnt_q ? m1_be       : m0_be;

    assign ddram_clk      = clk;
    assign ddram_addr     = g_addr;
    assign ddram_burstcnt = g_burst;
    assign ddram_din      = g_din;
    assign ddram_be       = g_be;
    assign m0_dout        = ddram_dout;
    assign m1_dout        = ddram_dout;
    assign unused_st      = ^st_addr[7:2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= 1'b0;
            lst_q   <= 1'b1;
            beats_q <= '0;
            done0_q <= '0;
            done1_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            lst_q   <= lst_d;
            beats_q <= beats_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
        end
    end

    // Next state plus the command/handshake outputs of the granted master
    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        lst_d         = lst_q;
        beats_d       = beats_q;
        done0_d       = done0_q;
        done1_d       = done1_q;
        burst_done    = 1'b0;
        ddram_rd      = 1'b0;
        ddram_we      = 1'b0;
        m0_busy       = 1'b1;
        m1_busy       = 1'b1;
        m0_dout_ready = 1'b0;
        m1_dout_ready = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req0 | req1) begin
                    gnt_d   = (req0 & req1) ? ~lst_q : req1;
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                ddram_rd = g_rd & ~g_we;
                ddram_we = g_we;
                if (gnt_q) m1_busy = ddram_busy;
                else       m0_busy = ddram_busy;
                if (!g_rd && !g_we) begin
                    state_d = ST_IDLE;
                end else if (!ddram_busy) begin
                    if (g_we) begin
                        if (g_burst <= BW'(1)) begin
                            state_d    = ST_IDLE;
                            burst_done = 1'b1;
                        end else begin
                            beats_d = g_burst - BW'(1);
                            state_d = ST_WDATA;
                        end
                    end else begin
                        beats_d = (g_burst == '0) ? BW'(1) : g_burst;
                        state_d = ST_RDATA;
                    end
                end
            end
            ST_RDATA: begin
                if (gnt_q) m1_dout_ready = ddram_dout_ready;
                else       m0_dout_ready = ddram_dout_ready;
                if (ddram_dout_ready) begin
                    beats_d = beats_q - BW'(1);
                    if (beats_q <= BW'(1)) begin
                        state_d    = ST_IDLE;
                        burst_done = 1'b1;
                    end
                end
            end
            ST_WDATA: begin
                ddram_we = g_we;
                if (gnt_q) m1_busy = ddram_busy;
                else       m0_busy = ddram_busy;
                if (g_we && !ddram_busy) begin
                    beats_d = beats_q - BW'(1);
                    if (beats_q <= BW'(1)) begin
                        state_d    = ST_IDLE;
                        burst_done = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A completed burst hands priority to the other master next time
        if (burst_done) begin
            lst_d = gnt_q;
            if (gnt_q) done1_d = done1_q + 8'd1;
            else       done0_d = done0_q + 8'd1;
        end
    end

    always_comb begin
        case (st_addr[1:0])
            2'd0:    st_dout = {4'd0, lst_q, gnt_q, 2'(state_q)};
            2'd1:    st_dout = done0_q;
            2'd2:    st_dout = done1_q;
            default: st_dout = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_jtframe_ddr_arb2.sv
// Directed and randomized bench for jtframe_ddr_arb2; a pending-request /
// round-robin / burst-count model supplies every expected value.
module tb_jtframe_ddr_arb2;
    localparam int unsigned AW = 29;
    localparam int unsigned BW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_rd, m0_we, m0_busy, m0_dout_ready;
    logic [AW-1:0] m0_addr;
    logic [BW-1:0] m0_burstcnt;
    logic [63:0]   m0_din, m0_dout;
    logic [7:0]    m0_be;
    logic          m1_rd, m1_we, m1_busy, m1_dout_ready;
    logic [AW-1:0] m1_addr;
    logic [BW-1:0] m1_burstcnt;
    logic [63:0]   m1_din, m1_dout;
    logic [7:0]    m1_be;
    logic          ddram_clk, ddram_rd, ddram_we, ddram_busy, ddram_dout_ready;
    logic [AW-1:0] ddram_addr;
    logic [BW-1:0] ddram_burstcnt;
    logic [63:0]   ddram_din, ddram_dout;
    logic [7:0]    ddram_be;
    logic [7:0]    st_addr, st_dout;

    int total = 0;
    int bad   = 0;
    int exp_cnt [2];
    int exp_lst;
    int order_q [$];

    always #5 clk = ~clk;

    jtframe_ddr_arb2 #(.AW(AW), .BW(BW)) dut (
        .clk(clk), .rst(rst),
        .m0_rd(m0_rd), .m0_we(m0_we), .m0_addr(m0_addr), .m0_burstcnt(m0_burstcnt),
        .m0_din(m0_din), .m0_be(m0_be), .m0_busy(m0_busy), .m0_dout(m0_dout),
        .m0_dout_ready(m0_dout_ready),
        .m1_rd(m1_rd), .m1_we(m1_we), .m1_addr(m1_addr), .m1_burstcnt(m1_burstcnt),
        .m1_din(m1_din), .m1_be(m1_be), .m1_busy(m1_busy), .m1_dout(m1_dout),
        .m1_dout_ready(m1_dout_ready),
        .ddram_clk(ddram_clk), .ddram_rd(ddram_rd), .ddram_we(ddram_we),
        .ddram_addr(ddram_addr), .ddram_burstcnt(ddram_burstcnt), .ddram_din(ddram_din),
        .ddram_be(ddram_be), .ddram_busy(ddram_busy), .ddram_dout(ddram_dout),
        .ddram_dout_ready(ddram_dout_ready),
        .st_addr(st_addr), .st_dout(st_dout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic busy_of(input int g);
        return (g == 0) ? m0_busy : m1_busy;
    endfunction

    function automatic logic rdy_of(input int g);
        return (g == 0) ? m0_dout_ready : m1_dout_ready;
    endfunction

    task automatic st_rd(input logic [1:0] a, output logic [7:0] v);
        st_addr = {6'($urandom_range(0, 63)), a};
        #1;
        v = st_dout;
    endtask

    task automatic chk_state(input string tag, input int g, input logic [1:0] s);
        logic [7:0] v;
        st_rd(2'd0, v);
        chk(tag, 64'(v), 64'({4'd0, 1'(exp_lst), 1'(g), s}));
    endtask

    task automatic chk_idle(input string tag, input int g);
        logic [7:0] v;
        chk_state({tag, "_st"}, g, 2'd0);
        st_rd(2'd1, v);
        chk({tag, "_cnt0"}, 64'(v), 64'(8'(exp_cnt[0])));
        st_rd(2'd2, v);
        chk({tag, "_cnt1"}, 64'(v), 64'(8'(exp_cnt[1])));
        st_rd(2'd3, v);
        chk({tag, "_st3"}, 64'(v), 64'd0);
    endtask

    task automatic chk_reset(input string tag);
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
        exp_lst    = 1;
        chk({tag, "_rd"},    64'(ddram_rd), 64'd0);
        chk({tag, "_we"},    64'(ddram_we), 64'd0);
        chk({tag, "_busy0"}, 64'(m0_busy), 64'd1);
        chk({tag, "_busy1"}, 64'(m1_busy), 64'd1);
        chk({tag, "_rdy0"},  64'(m0_dout_ready), 64'd0);
        chk({tag, "_rdy1"},  64'(m1_dout_ready), 64'd0);
        chk_idle(tag, 0);
    endtask

    task automatic drive(input int g, input logic rd, input logic we,
                         input logic [AW-1:0] a, input logic [BW-1:0] bc);
        if (g == 0) begin
            m0_rd = rd; m0_we = we; m0_addr = a; m0_burstcnt = bc;
            m0_din = {$urandom, $urandom}; m0_be = 8'($urandom);
        end else begin
            m1_rd = rd; m1_we = we; m1_addr = a; m1_burstcnt = bc;
            m1_din = {$urandom, $urandom}; m1_be = 8'($urandom);
        end
    endtask

    task automatic set_wbeat(input int g, input logic we, input logic [63:0] d, input logic [7:0] be);
        if (g == 0) begin
            m0_we = we; m0_din = d; m0_be = be;
        end else begin
            m1_we = we; m1_din = d; m1_be = be;
        end
    endtask

    task automatic finish_burst(input int g);
        exp_cnt[g] = (exp_cnt[g] + 1) % 256;
        exp_lst    = g;
    endtask

    task automatic wait_grant(output int g);
        g = -1;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (m0_busy === 1'b0) g = 0;
            else if (m1_busy === 1'b0) g = 1;
            if (g >= 0) break;
        end
        chk("grant_seen", 64'(g >= 0), 64'd1);
    endtask

    // Called in the CMD cycle of a granted read; leaves the arbiter in RDATA
    task automatic read_cmd(input int g, input logic [AW-1:0] a, input logic [BW-1:0] bc);
        chk("rd_cmd_rd", 64'(ddram_rd), 64'd1);
        chk("rd_cmd_we", 64'(ddram_we), 64'd0);
        chk("rd_cmd_addr", 64'(ddram_addr), 64'(a));
        chk("rd_cmd_bc", 64'(ddram_burstcnt), 64'(bc));
        chk("rd_cmd_other_busy", 64'(busy_of(1 - g)), 64'd1);
        chk_state("rd_cmd_st", g, 2'd1);
        tick();
        drive(g, 1'b0, 1'b0, a, bc);
        settle();
        chk("rd_acc_rd", 64'(ddram_rd), 64'd0);
    endtask

    task automatic read_beats(input int g, input int n);
        logic [63:0] d;
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                ddram_dout_ready = 1'b0;
                settle();
                chk("rd_gap_rdy", 64'(rdy_of(g)), 64'd0);
                chk_state("rd_gap_st", g, 2'd2);
                tick();
            end
            d = {$urandom, $urandom};
            ddram_dout       = d;
            ddram_dout_ready = 1'b1;
            settle();
            chk("rd_beat_rdy", 64'(rdy_of(g)), 64'd1);
            chk("rd_beat_other", 64'(rdy_of(1 - g)), 64'd0);
            chk("rd_dout0", m0_dout, d);
            chk("rd_dout1", m1_dout, d);
            chk("rd_busy", 64'(busy_of(g)), 64'd1);
            tick();
        end
        ddram_dout_ready = 1'b0;
        finish_burst(g);
        settle();
        chk_idle("rd_done", g);
    endtask

    // Called in the CMD cycle of a granted write; returns in IDLE
    task automatic write_burst(input int g, input logic [AW-1:0] a, input logic [BW-1:0] bc,
                               input int stall_beat, input int stall_len, input bit gaps);
        int          n, acc, stalled;
        logic        we;
        logic [63:0] d;
        logic [7:0]  be;
        n       = (bc == '0) ? 1 : int'(bc);
        acc     = 0;
        stalled = 0;
        for (int c = 0; c < 64 && acc < n; c++) begin
            ddram_busy = (acc + 1 == stall_beat) && (stalled < stall_len);
            if (ddram_busy) stalled++;
            we = !(gaps && acc > 0 && $urandom_range(0, 3) == 0);
            d  = {$urandom, $urandom};
            be = 8'($urandom);
            set_wbeat(g, we, d, be);
            settle();
            chk_state("wr_st", g, (acc == 0) ? 2'd1 : 2'd3);
            chk("wr_busy", 64'(busy_of(g)), 64'(ddram_busy));
            chk("wr_other_busy", 64'(busy_of(1 - g)), 64'd1);
            chk("wr_ddr_we", 64'(ddram_we), 64'(we));
            chk("wr_ddr_rd", 64'(ddram_rd), 64'd0);
            if (we) begin
                chk("wr_din", ddram_din, d);
                chk("wr_be", 64'(ddram_be), 64'(be));
                chk("wr_addr", 64'(ddram_addr), 64'(a));
            end
            if (we && !ddram_busy) acc++;
            tick();
        end
        chk("wr_beats", 64'(acc), 64'(n));
        drive(g, 1'b0, 1'b0, a, bc);
        ddram_busy = 1'b0;
        finish_burst(g);
        settle();
        chk_idle("wr_done", g);
    endtask

    // Model: pending requests are granted one at a time, the master that was
    // not served last wins on contention, each served burst runs to completion.
    task automatic serve_all(input bit p0, input bit p1, input bit w0, input bit w1,
                             input logic [BW-1:0] b0, input logic [BW-1:0] b1, input bit stalls);
        bit            pend [2];
        bit            wr   [2];
        logic [BW-1:0] bc   [2];
        logic [AW-1:0] ad   [2];
        int            g, eg, nb;
        pend[0] = p0; pend[1] = p1;
        wr[0]   = w0; wr[1]   = w1;
        bc[0]   = b0; bc[1]   = b1;
        for (int m = 0; m < 2; m++) begin
            ad[m] = AW'($urandom);
            if (pend[m]) drive(m, !wr[m], wr[m], ad[m], bc[m]);
        end
        for (int it = 0; it < 2 && (pend[0] || pend[1]); it++) begin
            eg = (pend[0] && pend[1]) ? 1 - exp_lst : (pend[1] ? 1 : 0);
            wait_grant(g);
            chk("arb_grant", 64'(g), 64'(eg));
            if (g < 0) break;
            order_q.push_back(g);
            nb = (bc[g] == '0) ? 1 : int'(bc[g]);
            if (wr[g]) begin
                write_burst(g, ad[g], bc[g], stalls ? int'($urandom_range(0, nb)) : 0,
                            stalls ? int'($urandom_range(0, 2)) : 0, stalls);
            end else begin
                read_cmd(g, ad[g], bc[g]);
                read_beats(g, nb);
            end
            pend[g] = 1'b0;
        end
    endtask

    task automatic do_reset(input string tag);
        tick();
        rst = 1'b1;
        settle();
        chk_reset(tag);
        tick();
        rst = 1'b0;
        settle();
    endtask

    initial begin
        int          g;
        logic [7:0]  v;
        bit          p0, p1;
        rst = 1'b1;
        m0_rd = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_burstcnt = '0; m0_din = '0; m0_be = '0;
        m1_rd = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_burstcnt = '0; m1_din = '0; m1_be = '0;
        ddram_busy = 1'b0; ddram_dout = '0; ddram_dout_ready = 1'b0; st_addr = '0;
        settle();
        chk_reset("reset");
        chk("ddram_clk", 64'(ddram_clk), 64'(clk));
        tick();
        rst = 1'b0;

        // single m0 read of 4 beats at 0x100
        drive(0, 1'b1, 1'b0, 29'h100, 8'd4);
        wait_grant(g);
        chk("r034_grant", 64'(g), 64'd0);
        read_cmd(0, 29'h100, 8'd4);
        read_beats(0, 4);
        st_rd(2'd1, v);
        chk("r034_cnt0", 64'(v), 64'd1);

        // contention after reset alternates starting with m0
        do_reset("reset2");
        order_q.delete();
        serve_all(1'b1, 1'b1, 1'b0, 1'b0, 8'd2, 8'd2, 1'b0);
        serve_all(1'b1, 1'b1, 1'b0, 1'b0, 8'd2, 8'd2, 1'b0);
        chk("r035_n", 64'(order_q.size()), 64'd4);
        for (int i = 0; i < 4 && i < order_q.size(); i++)
            chk("r035_order", 64'(order_q[i]), 64'(i % 2));

        // m1 write of 3 beats, DDR stalls two cycles on beat 2
        drive(1, 1'b0, 1'b1, 29'h2000, 8'd3);
        wait_grant(g);
        chk("r036_grant", 64'(g), 64'd1);
        write_burst(1, 29'h2000, 8'd3, 2, 2, 1'b0);

        // m0 withdraws its read while DDR is busy
        ddram_busy = 1'b1;
        drive(0, 1'b1, 1'b0, 29'h300, 8'd4);
        tick();
        chk_state("r037_cmd", 0, 2'd1);
        chk("r037_busy0", 64'(m0_busy), 64'd1);
        chk("r037_busy1", 64'(m1_busy), 64'd1);
        chk("r037_rd", 64'(ddram_rd), 64'd1);
        drive(0, 1'b0, 1'b0, 29'h300, 8'd4);
        settle();
        chk("r037_rd_drop", 64'(ddram_rd), 64'd0);
        tick();
        ddram_busy = 1'b0;
        settle();
        chk_idle("r037_idle", 0);

        // zero-length write with rd also high behaves as one-beat write
        drive(0, 1'b1, 1'b1, 29'h440, 8'd0);
        wait_grant(g);
        chk("r039_grant", 64'(g), 64'd0);
        write_burst(0, 29'h440, 8'd0, 0, 0, 1'b0);

        for (int it = 0; it < 14; it++) begin
            p0 = 1'($urandom_range(0, 1));
            p1 = 1'($urandom_range(0, 1));
            if (!p0 && !p1) p1 = 1'b1;
            serve_all(p0, p1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      8'($urandom_range(0, 5)), 8'($urandom_range(0, 5)), 1'b1);
        end

        // reset in the middle of an 8-beat read; stale beats must be dropped
        drive(0, 1'b1, 1'b0, 29'h500, 8'd8);
        wait_grant(g);
        chk("r038_grant", 64'(g), 64'd0);
        read_cmd(0, 29'h500, 8'd8);
        for (int k = 0; k < 2; k++) begin
            ddram_dout = {$urandom, $urandom};
            ddram_dout_ready = 1'b1;
            settle();
            chk("r038_pre_rdy", 64'(m0_dout_ready), 64'd1);
            tick();
        end
        rst = 1'b1;
        settle();
        chk_reset("r038_rst");
        tick();
        rst = 1'b0;
        drive(1, 1'b1, 1'b0, 29'h600, 8'd2);
        ddram_dout = {$urandom, $urandom};
        settle();
        chk("r038_stale_idle0", 64'(m0_dout_ready), 64'd0);
        chk("r038_stale_idle1", 64'(m1_dout_ready), 64'd0);
        tick();
        ddram_busy = 1'b1;
        for (int s = 0; s < 4; s++) begin
            ddram_dout = {$urandom, $urandom};
            settle();
            chk("r038_stale_cmd0", 64'(m0_dout_ready), 64'd0);
            chk("r038_stale_cmd1", 64'(m1_dout_ready), 64'd0);
            chk("r038_cmd_busy", 64'(m1_busy), 64'd1);
            tick();
        end
        ddram_busy = 1'b0;
        ddram_dout = {$urandom, $urandom};
        settle();
        chk("r038_acc_busy", 64'(m1_busy), 64'd0);
        chk("r038_acc_rd", 64'(ddram_rd), 64'd1);
        chk("r038_acc_rdy", 64'(m1_dout_ready), 64'd0);
        tick();
        drive(1, 1'b0, 1'b0, 29'h600, 8'd2);
        read_beats(1, 2);
        tick();
        ddram_dout_ready = 1'b1;
        settle();
        chk("r038_late_rdy0", 64'(m0_dout_ready), 64'd0);
        chk("r038_late_rdy1", 64'(m1_dout_ready), 64'd0);
        ddram_dout_ready = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
